// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths and initiator FSM state encodings.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog counter: counts BUS cycles without ack/err and flags
// the final allowed cycle. Only instantiated when WB_TIMEOUT_EN is defined.
module wb_timeout_ctr #(
   parameter int LIMIT = 256,
   parameter int CNT_W = $clog2(LIMIT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + 1'b1;
   end

   assign expired = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator, one outstanding transfer.
// Define WB_TIMEOUT_EN to abort bus cycles that see no ack/err in TIMEOUT_CYCLES.
module wb_initiator
   import wb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [ADDR_W-1:0]    req_addr_i,
   input  logic                 req_we_i,
   input  logic [WB_SEL_W-1:0]  req_sel_i,
   input  logic [WB_DATA_W-1:0] req_wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [WB_DATA_W-1:0] rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [ADDR_W-1:0]    wb_adr_o,
   output logic [WB_SEL_W-1:0]  wb_sel_o,
   output logic [WB_DATA_W-1:0] wb_dat_o,
   input  logic [WB_DATA_W-1:0] wb_dat_i,
   input  logic                 wb_ack_i,
   input  logic                 wb_err_i
);

   wb_state_e state;
   logic      accept;
   logic      bus_done;
   logic      timeout_hit;

   assign accept   = req_valid_i & req_ready_o;
   assign bus_done = wb_ack_i | wb_err_i;

`ifdef WB_TIMEOUT_EN
   // Counter is cleared on the accept edge, so it reads 0 in the first BUS cycle.
   wb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .clear   (accept),
      .enable  ((state == ST_BUS) && !bus_done),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state       <= ST_IDLE;
         req_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= '0;
         wb_sel_o    <= '0;
         wb_dat_o    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  req_ready_o <= 1'b0;
                  wb_adr_o    <= req_addr_i;
                  wb_we_o     <= req_we_i;
                  wb_sel_o    <= req_sel_i;
                  wb_dat_o    <= req_wdata_i;
                  wb_cyc_o    <= 1'b1;
                  wb_stb_o    <= 1'b1;
                  state       <= ST_BUS;
               end
            end
            ST_BUS: begin
               // A timeout with no ack/err reports as an error; err beats ack.
               if (bus_done || timeout_hit) begin
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= wb_err_i | !bus_done;
                  rsp_rdata_o <= (!wb_we_o && wb_ack_i && !wb_err_i) ? wb_dat_i : '0;
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state       <= ST_IDLE;
               req_ready_o <= 1'b1;
               rsp_valid_o <= 1'b0;
               wb_cyc_o    <= 1'b0;
               wb_stb_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator with a configurable-latency Wishbone responder.
// Build with WB_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYCLES=8).
module tb_wb_initiator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_sel = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_rdata;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel;
   logic        wb_ack, wb_err;

   // responder model state
   logic        resp_en = 1'b0, err_mode = 1'b0, stray_ack = 1'b0;
   int          ack_wait = 0;
   int          wcnt = 0;
   logic [31:0] rd_val = '0;
   logic        ack_r = 1'b0, err_r = 1'b0;
   logic [31:0] dat_r = '0;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   assign wb_ack   = ack_r | stray_ack;
   assign wb_err   = err_r;
   assign wb_dat_i = dat_r;

   // Registered ack: seen by the initiator ack_wait+1 edges after stb is sampled.
   always @(posedge clk) begin
      if (resp_en && wb_cyc && wb_stb && !ack_r && !err_r) begin
         if (wcnt >= ack_wait) begin
            ack_r <= 1'b1;
            err_r <= err_mode;
            dat_r <= rd_val;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         ack_r <= 1'b0;
         err_r <= 1'b0;
         wcnt  <= 0;
      end
   end

   wb_initiator #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_addr_i  (req_addr),
      .req_we_i    (req_we),
      .req_sel_i   (req_sel),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .wb_cyc_o    (wb_cyc),
      .wb_stb_o    (wb_stb),
      .wb_we_o     (wb_we),
      .wb_adr_o    (wb_adr),
      .wb_sel_o    (wb_sel),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i),
      .wb_ack_i    (wb_ack),
      .wb_err_i    (wb_err)
   );

   // Issue one request, then step until rsp_valid (bounded), recording stb length
   // and whether bus outputs matched the request on every stb cycle.
   task automatic run_xfer(input logic we, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output int stb_cyc,
                           output logic stable, output logic rdy_low);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_sel = s; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      stb_cyc = 0; stable = 1'b1; rdy_low = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (rsp_valid) break;
         if (wb_cyc && wb_stb) stb_cyc++;
         if (!(wb_cyc && wb_stb) || wb_adr !== a || wb_we !== we || wb_sel !== s ||
             (we && wb_dat_o !== d)) stable = 1'b0;
         if (req_ready) rdy_low = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected %b",
                  {req_ready, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we}, 6'b100000);
      end
      checks++;
      if ({rsp_rdata, wb_adr, wb_dat_o, wb_sel} !== 100'd0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0", {rsp_rdata, wb_adr, wb_dat_o, wb_sel});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_read();
      int n; logic st, rl;
      resp_en = 1'b1; ack_wait = 0; err_mode = 1'b0; rd_val = 32'hA5A5_0001;
      run_xfer(1'b0, 32'h40, 4'hF, 32'h0, n, st, rl);
      checks++;
      if (n !== 2) begin errors++; $display("FAIL read_stb_len: got %0d expected 2", n); end
      checks++;
      if (st !== 1'b1 || rl !== 1'b1) begin
         errors++; $display("FAIL read_bus_stable: got %b%b expected 11", st, rl);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hA5A5_0001}) begin
         errors++;
         $display("FAIL read_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=a5a50001",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      consume();
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         errors++; $display("FAIL read_handshake: got %b expected 01", {rsp_valid, req_ready});
      end
   endtask

   task automatic test_write();
      int n; logic st, rl;
      resp_en = 1'b1; ack_wait = 0; err_mode = 1'b0; rd_val = 32'hDEAD_BEEF;
      run_xfer(1'b1, 32'h44, 4'b0011, 32'h0100_0001, n, st, rl);
      checks++;
      if (st !== 1'b1 || n !== 2) begin
         errors++; $display("FAIL write_bus: got stable=%b len=%0d expected 1/2", st, n);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin
         errors++;
         $display("FAIL write_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=0",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      consume();
   endtask

   task automatic test_hold();
      int n; logic st, rl; logic bad;
      resp_en = 1'b1; ack_wait = 4; err_mode = 1'b0; rd_val = 32'h1234_5678;
      run_xfer(1'b0, 32'h48, 4'hF, 32'h0, n, st, rl);
      checks++;
      if (n !== 6 || st !== 1'b1) begin
         errors++; $display("FAIL hold_stb_len: got %0d stable=%b expected 6/1", n, st);
      end
      checks++;
      if (rl !== 1'b1) begin errors++; $display("FAIL hold_ready_low: got %b expected 1", rl); end
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (!rsp_valid || rsp_rdata !== 32'h1234_5678 || rsp_err || req_ready || wb_cyc) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (bad !== 1'b0 || rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_rsp_stable: got v=%b d=%h rdy=%b expected v=1 d=12345678 rdy=0",
                  rsp_valid, rsp_rdata, req_ready);
      end
      consume();
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         errors++; $display("FAIL hold_release: got %b expected 01", {rsp_valid, req_ready});
      end
      ack_wait = 0;
   endtask

   task automatic test_err();
      int n; logic st, rl;
      resp_en = 1'b1; ack_wait = 0; err_mode = 1'b1; rd_val = 32'hFFFF_FFFF;
      run_xfer(1'b0, 32'h4C, 4'hF, 32'h0, n, st, rl);
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
         errors++;
         $display("FAIL err_rsp: got v=%b e=%b d=%h expected v=1 e=1 d=0",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      consume();
      err_mode = 1'b0;
   endtask

   task automatic test_stray_ack();
      @(negedge clk);
      stray_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      stray_ack = 1'b0;
      checks++;
      if ({rsp_valid, req_ready, wb_cyc} !== 3'b010) begin
         errors++; $display("FAIL stray_ack: got %b expected 010", {rsp_valid, req_ready, wb_cyc});
      end
   endtask

   task automatic test_back_to_back();
      int acc = 0;
      resp_en = 1'b1; ack_wait = 0; rd_val = 32'h0000_0B2B;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h60; req_sel = 4'hF;
      for (int i = 0; i < 12; i++) begin
         if (req_valid && req_ready) acc++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      checks++;
      if (acc !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", acc); end
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

`ifdef WB_TIMEOUT_EN
   task automatic test_timeout();
      int n; logic st, rl;
      resp_en = 1'b0;
      run_xfer(1'b0, 32'h50, 4'hF, 32'h0, n, st, rl);
      checks++;
      if (n !== 8 || {rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
         errors++;
         $display("FAIL timeout_abort: got len=%0d v=%b e=%b d=%h expected 8/1/1/0",
                  n, rsp_valid, rsp_err, rsp_rdata);
      end
      consume();
      resp_en = 1'b1; ack_wait = 6; rd_val = 32'hCAFE_0008;
      run_xfer(1'b0, 32'h54, 4'hF, 32'h0, n, st, rl);
      checks++;
      if (n !== 8 || {rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hCAFE_0008}) begin
         errors++;
         $display("FAIL timeout_ack_wins: got len=%0d v=%b e=%b d=%h expected 8/1/0/cafe0008",
                  n, rsp_valid, rsp_err, rsp_rdata);
      end
      consume();
      ack_wait = 0;
   endtask
`else
   task automatic test_wait_forever();
      resp_en = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h50; req_sel = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if ({wb_cyc, wb_stb, rsp_valid} !== 3'b110) begin
         errors++; $display("FAIL no_timeout_wait: got %b expected 110", {wb_cyc, wb_stb, rsp_valid});
      end
      resp_en = 1'b1; ack_wait = 0; rd_val = 32'h0000_0777;
      for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0000_0777}) begin
         errors++;
         $display("FAIL no_timeout_done: got v=%b e=%b d=%h expected v=1 e=0 d=00000777",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      consume();
   endtask
`endif

   task automatic test_reset_mid();
      int n; logic st, rl; logic seen;
      resp_en = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h70; req_sel = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({wb_cyc, wb_stb, rsp_valid, req_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_mid_async: got %b expected 0001", {wb_cyc, wb_stb, rsp_valid, req_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
      resp_en = 1'b1; ack_wait = 0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid || wb_cyc) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_rsp: got %b expected 0", seen); end
      rd_val = 32'h0000_AAAA;
      run_xfer(1'b0, 32'h74, 4'hF, 32'h0, n, st, rl);
      checks++;
      if (n !== 2 || {rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0000_AAAA}) begin
         errors++;
         $display("FAIL reset_mid_recover: got len=%0d v=%b e=%b d=%h expected 2/1/0/0000aaaa",
                  n, rsp_valid, rsp_err, rsp_rdata);
      end
      consume();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_read();
      test_write();
      test_hold();
      test_err();
      test_stray_ack();
      test_back_to_back();
`ifdef WB_TIMEOUT_EN
      test_timeout();
`else
      test_wait_forever();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
